controle_medicao_periodica: RTL and testbench
=============================================

Name: controle_medicao_periodica

Overview:
Scheduler that sequences the sensor station's measure-and-report cycle. It requests a reading from the sensor interface at a fixed period and latches temperature/humidity. It then starts `transmissao_medida` with a one-cycle `transmite` pulse and waits for its `pronto` before the next cycle. It sits between the sensor driver and the serial transmission block in the top level.

Parameters:
- INTERVALO, 50_000_000: clock cycles between successive measurement starts (1 s at 50 MHz); must exceed worst-case cycle length.
- TIMEOUT_SENSOR, 1_000_000: max cycles waiting for `sensor_pronto` after `medir`.
- LARGURA_TIMER, 26: width of interval and timeout counters; must hold INTERVALO-1.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- ligar, in, 1: level; 1 enables periodic operation.
- medir, out, 1: one-cycle pulse requesting a sensor reading.
- sensor_pronto, in, 1: one-cycle pulse; reading valid on sensor_* this cycle.
- sensor_erro, in, 1: qualified by sensor_pronto; reading invalid.
- sensor_temperatura, in, 16: raw temperature.
- sensor_umidade, in, 16: raw humidity.
- transmite, out, 1: one-cycle start pulse to the transmitter.
- transmissao_pronto, in, 1: transmitter done pulse.
- temperatura, out, 16: latched value presented to the transmitter.
- umidade, out, 16: latched value presented to the transmitter.
- ocupado, out, 1: high in any state except INICIAL/ESPERA.
- erro_sensor, out, 1: sticky; set on sensor error/timeout; cleared at next successful latch.
- db_estado, out, 4: current state encoding, for debug.

Behaviour:
- Reset (async, any state): state=INICIAL, all outputs 0, timers 0, latched values 0x0000.
- States and encodings: INICIAL(0), ESPERA(1), PEDE(2), AGUARDA_SENSOR(3), ARMAZENA(4), TRANSMITE(5), AGUARDA_TX(6), ERRO(F).
- INICIAL: if `ligar`, go to PEDE next cycle and clear the interval timer.
- PEDE: `medir`=1 for exactly this cycle; timeout counter cleared; go to AGUARDA_SENSOR.
- AGUARDA_SENSOR:
  - `sensor_pronto`&!`sensor_erro` -> ARMAZENA.
  - `sensor_pronto`&`sensor_erro` -> ERRO.
  - Timeout counter reaches TIMEOUT_SENSOR-1 without `sensor_pronto` -> ERRO.
- ARMAZENA: latch `temperatura`/`umidade` from the sensor_* values registered on the `sensor_pronto` cycle; clear `erro_sensor`; go to TRANSMITE.
- TRANSMITE: `transmite`=1 for one cycle; latched outputs are stable from this cycle until the next ARMAZENA; go to AGUARDA_TX.
- AGUARDA_TX: on `transmissao_pronto` -> ESPERA. No timeout; the transmitter is guaranteed to finish.
- ERRO: set `erro_sensor`; latched values unchanged; go to ESPERA (no transmission this period).
- ESPERA:
  - Interval timer free-runs from the PEDE cycle; PEDE is re-entered exactly INTERVALO cycles after the previous PEDE.
  - If `ligar`=0 in ESPERA, go to INICIAL.
- Interval timer: runs continuously from PEDE regardless of state and wraps at INTERVALO-1. A period expiry while still busy is dropped; the next PEDE occurs at the next wrap.
- `ligar` deasserted mid-cycle: the current cycle completes (the transmission is never aborted), then ESPERA -> INICIAL.
- `sensor_pronto` outside AGUARDA_SENSOR and `transmissao_pronto` outside AGUARDA_TX: ignored.
- Latency: `medir` appears 1 cycle after `ligar` rises in INICIAL; `transmite` appears 2 cycles after an accepted `sensor_pronto`.

Optional Feature:
- Macro: CONTROLE_MEDICAO_RETENTATIVA_EN.
- Defined: the first error or timeout in a period goes back to PEDE (one retry, `medir` re-pulsed) instead of ERRO; a second failure goes to ERRO. The retry flag clears at each PEDE issued from ESPERA/INICIAL.
- Undefined: the first failure goes straight to ERRO; no retry logic is synthesized.

Decomposition:
- Package `medicao_pkg`:
  - state enum/localparams with the encodings above;
  - LARGURA_DADO=16;
  - default INTERVALO/TIMEOUT constants.
- One sub-module: `contador_m` (parameterised modulo-M counter with clear, enable and end-of-count flag), instantiated twice (interval, timeout).

Test Plan (INTERVALO=200, TIMEOUT_SENSOR=20):
- Reset, `ligar`=1; sensor answers 5 cycles after `medir` with 0x1524/0x095E -> `transmite` pulse 2 cycles later, `temperatura`=0x1524, `umidade`=0x095E; after `transmissao_pronto`, next `medir` exactly 200 cycles after the first.
- Sensor never responds -> ERRO after 20 cycles; `erro_sensor`=1; no `transmite`; outputs keep their previous values; next period succeeds and clears `erro_sensor`.
- `sensor_pronto` with `sensor_erro`=1 -> same as timeout. With CONTROLE_MEDICAO_RETENTATIVA_EN: a second `medir` follows, and a success on retry transmits normally.
- `ligar` dropped during AGUARDA_TX -> `transmite` cycle completes, returns to INICIAL, no further `medir`.
- Transmitter holds for 250 cycles (longer than INTERVALO) -> the missed period is skipped; the next `medir` is at the 400-cycle mark.
- Reset asserted mid AGUARDA_SENSOR -> all outputs 0 immediately (asynchronous); `db_estado`=0.

Source files
------------

// File: rtl/medicao_pkg.sv
// Shared types and defaults for the periodic measurement scheduler.
package medicao_pkg;

  localparam int LARGURA_DADO          = 16;
  localparam int INTERVALO_PADRAO      = 50_000_000;
  localparam int TIMEOUT_SENSOR_PADRAO = 1_000_000;
  localparam int LARGURA_TIMER_PADRAO  = 26;

  // Encodings are visible on db_estado and must stay fixed.
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    ESPERA         = 4'h1,
    PEDE           = 4'h2,
    AGUARDA_SENSOR = 4'h3,
    ARMAZENA       = 4'h4,
    TRANSMITE      = 4'h5,
    AGUARDA_TX     = 4'h6,
    ERRO           = 4'hF
  } estado_t;

endpackage

// File: rtl/contador_m.sv
// Modulo-M counter with synchronous clear, count enable and end-of-count flag.
module contador_m #(
  parameter int M = 100,
  parameter int N = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);
  logic [N-1:0] valor_q, valor_d;

  // NOTE: every signal written here gets its default first, so no path infers a latch.
  always_comb begin
    valor_d = valor_q;
    if (zera) begin
      valor_d = '0;
    end else if (conta) begin
      valor_d = (valor_q == N'(M - 1)) ? '0 : valor_q + N'(1);
    end
  end

  // NOTE: state registers use <= so all flops sample their pre-edge values together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valor_q <= '0;
    else       valor_q <= valor_d;
  end

  assign fim = (valor_q == N'(M - 1));

endmodule

// File: rtl/controle_medicao_periodica.sv
// Periodic measure-and-report scheduler between the sensor driver and the serial transmitter.
// Optional single retry after a sensor failure: define CONTROLE_MEDICAO_RETENTATIVA_EN.
module controle_medicao_periodica
  import medicao_pkg::*;
#(
  parameter int INTERVALO      = INTERVALO_PADRAO,
  parameter int TIMEOUT_SENSOR = TIMEOUT_SENSOR_PADRAO,
  parameter int LARGURA_TIMER  = LARGURA_TIMER_PADRAO
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ligar,
  output logic                    medir,
  input  logic                    sensor_pronto,
  input  logic                    sensor_erro,
  input  logic [LARGURA_DADO-1:0] sensor_temperatura,
  input  logic [LARGURA_DADO-1:0] sensor_umidade,
  output logic                    transmite,
  input  logic                    transmissao_pronto,
  output logic [LARGURA_DADO-1:0] temperatura,
  output logic [LARGURA_DADO-1:0] umidade,
  output logic                    ocupado,
  output logic                    erro_sensor,
  output logic [3:0]              db_estado
);

  estado_t                 estado_q, estado_d;
  estado_t                 destino_falha;
  logic [LARGURA_DADO-1:0] leitura_temp_q, leitura_temp_d;
  logic [LARGURA_DADO-1:0] leitura_umid_q, leitura_umid_d;
  logic [LARGURA_DADO-1:0] temperatura_q, temperatura_d;
  logic [LARGURA_DADO-1:0] umidade_q, umidade_d;
  logic                    erro_sensor_q, erro_sensor_d;
  logic                    fim_intervalo, fim_timeout;

  // Interval timer free-runs from the period's PEDE; it only sits at zero while idle.
  contador_m #(.M(INTERVALO), .N(LARGURA_TIMER)) u_intervalo (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q == INICIAL),
    .conta (1'b1),
    .fim   (fim_intervalo)
  );

  contador_m #(.M(TIMEOUT_SENSOR), .N(LARGURA_TIMER)) u_timeout (
    .clock (clock),
    .reset (reset),
    .zera  (estado_q == PEDE),
    .conta (estado_q == AGUARDA_SENSOR),
    .fim   (fim_timeout)
  );

`ifdef CONTROLE_MEDICAO_RETENTATIVA_EN
  logic retentou_q, retentou_d;

  assign destino_falha = retentou_q ? ERRO : PEDE;

  // A retry is spent by the PEDE re-issued from AGUARDA_SENSOR; a fresh period restores it.
  always_comb begin
    retentou_d = retentou_q;
    if (estado_d == PEDE) begin
      if (estado_q == AGUARDA_SENSOR) retentou_d = 1'b1;
      else                            retentou_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) retentou_q <= 1'b0;
    else       retentou_q <= retentou_d;
  end
`else
  assign destino_falha = ERRO;
`endif

  always_comb begin
    estado_d       = estado_q;
    leitura_temp_d = leitura_temp_q;
    leitura_umid_d = leitura_umid_q;
    temperatura_d  = temperatura_q;
    umidade_d      = umidade_q;
    erro_sensor_d  = erro_sensor_q;

    case (estado_q)
      INICIAL: if (ligar) estado_d = PEDE;
      ESPERA: begin
        if (!ligar)             estado_d = INICIAL;
        else if (fim_intervalo) estado_d = PEDE;
      end
      PEDE: estado_d = AGUARDA_SENSOR;
      AGUARDA_SENSOR: begin
        if (sensor_pronto) begin
          leitura_temp_d = sensor_temperatura;
          leitura_umid_d = sensor_umidade;
          estado_d       = sensor_erro ? destino_falha : ARMAZENA;
        end else if (fim_timeout) begin
          estado_d = destino_falha;
        end
      end
      ARMAZENA: begin
        temperatura_d = leitura_temp_q;
        umidade_d     = leitura_umid_q;
        erro_sensor_d = 1'b0;
        estado_d      = TRANSMITE;
      end
      TRANSMITE:  estado_d = AGUARDA_TX;
      AGUARDA_TX: if (transmissao_pronto) estado_d = ESPERA;
      ERRO: begin
        erro_sensor_d = 1'b1;
        estado_d      = ESPERA;
      end
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q       <= INICIAL;
      leitura_temp_q <= '0;
      leitura_umid_q <= '0;
      temperatura_q  <= '0;
      umidade_q      <= '0;
      erro_sensor_q  <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      leitura_temp_q <= leitura_temp_d;
      leitura_umid_q <= leitura_umid_d;
      temperatura_q  <= temperatura_d;
      umidade_q      <= umidade_d;
      erro_sensor_q  <= erro_sensor_d;
    end
  end

  assign medir       = (estado_q == PEDE);
  assign transmite   = (estado_q == TRANSMITE);
  assign ocupado     = !(estado_q inside {INICIAL, ESPERA});
  assign erro_sensor = erro_sensor_q;
  assign temperatura = temperatura_q;
  assign umidade     = umidade_q;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_controle_medicao_periodica.sv
// Self-checking bench: period-arithmetic reference model compared every cycle, plus directed literal checks.
module tb_controle_medicao_periodica;

  localparam int INTERVALO = 200;
  localparam int TIMEOUT   = 20;

  logic        clock = 1'b0;
  logic        reset;
  logic        ligar, sensor_pronto, sensor_erro, transmissao_pronto;
  logic [15:0] sensor_temperatura, sensor_umidade;
  logic        medir, transmite, ocupado, erro_sensor;
  logic [15:0] temperatura, umidade;
  logic [3:0]  db_estado;

  int n_cmp = 0;
  int n_bad = 0;
  int ciclo = 0;
  int n_medir = 0;
  int n_tx = 0;

  controle_medicao_periodica #(
    .INTERVALO(INTERVALO), .TIMEOUT_SENSOR(TIMEOUT), .LARGURA_TIMER(26)
  ) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .medir(medir),
    .sensor_pronto(sensor_pronto), .sensor_erro(sensor_erro),
    .sensor_temperatura(sensor_temperatura), .sensor_umidade(sensor_umidade),
    .transmite(transmite), .transmissao_pronto(transmissao_pronto),
    .temperatura(temperatura), .umidade(umidade), .ocupado(ocupado),
    .erro_sensor(erro_sensor), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    ciclo++;
  end

  task automatic check(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
    n_cmp++;
    if (obtido !== esperado) begin
      n_bad++;
      $display("FAIL %s @ciclo %0d: got 0x%0h, expected 0x%0h", nome, ciclo, obtido, esperado);
    end
  endtask

  // Reference model: phases of the measure-and-report cycle, timing from cycle arithmetic.
  typedef enum {F_PARADO, F_ESPERANDO, F_PEDINDO, F_SENSOR, F_GUARDA, F_ENVIA, F_ENVIANDO, F_FALHA} fase_t;
  fase_t       fase = F_PARADO;
  int          cyc_m = 0, inicio_periodo = 0, inicio_sensor = 0;
  logic [15:0] m_temp = '0, m_umid = '0, cap_t = '0, cap_u = '0;
  logic        m_err = 1'b0;
  bit          tentou = 1'b0;

  function automatic logic [3:0] codigo(input fase_t f);
    case (f)
      F_PARADO:    return 4'h0;
      F_ESPERANDO: return 4'h1;
      F_PEDINDO:   return 4'h2;
      F_SENSOR:    return 4'h3;
      F_GUARDA:    return 4'h4;
      F_ENVIA:     return 4'h5;
      F_ENVIANDO:  return 4'h6;
      default:     return 4'hF;
    endcase
  endfunction

  function automatic fase_t apos_falha();
`ifdef CONTROLE_MEDICAO_RETENTATIVA_EN
    if (!tentou) begin
      tentou = 1'b1;
      return F_PEDINDO;
    end
`endif
    return F_FALHA;
  endfunction

  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      fase = F_PARADO; m_temp = '0; m_umid = '0; cap_t = '0; cap_u = '0;
      m_err = 1'b0; tentou = 1'b0; cyc_m = 0;
    end else begin
      cyc_m++;
      case (fase)
        F_PARADO: if (ligar) begin
          fase = F_PEDINDO; inicio_periodo = cyc_m; tentou = 1'b0;
        end
        F_ESPERANDO: begin
          if (!ligar) fase = F_PARADO;
          else if ((cyc_m - inicio_periodo) % INTERVALO == 0) begin
            fase = F_PEDINDO; inicio_periodo = cyc_m; tentou = 1'b0;
          end
        end
        F_PEDINDO: begin
          fase = F_SENSOR; inicio_sensor = cyc_m;
        end
        F_SENSOR: begin
          if (sensor_pronto) begin
            cap_t = sensor_temperatura; cap_u = sensor_umidade;
            fase = sensor_erro ? apos_falha() : F_GUARDA;
          end else if (cyc_m - inicio_sensor == TIMEOUT) begin
            fase = apos_falha();
          end
        end
        F_GUARDA: begin
          m_temp = cap_t; m_umid = cap_u; m_err = 1'b0; fase = F_ENVIA;
        end
        F_ENVIA:    fase = F_ENVIANDO;
        F_ENVIANDO: if (transmissao_pronto) fase = F_ESPERANDO;
        default: begin
          m_err = 1'b1; fase = F_ESPERANDO;
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clock);
    check("medir",       32'(medir),       32'(fase == F_PEDINDO));
    check("transmite",   32'(transmite),   32'(fase == F_ENVIA));
    check("ocupado",     32'(ocupado),     32'(!(fase inside {F_PARADO, F_ESPERANDO})));
    check("erro_sensor", 32'(erro_sensor), 32'(m_err));
    check("temperatura", 32'(temperatura), 32'(m_temp));
    check("umidade",     32'(umidade),     32'(m_umid));
    check("db_estado",   32'(db_estado),   32'(codigo(fase)));
    if (medir) n_medir++;
    if (transmite) n_tx++;
  end

  task automatic ate(input int n);
    while (ciclo < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic resposta(input int c, input logic err, input logic [15:0] t, input logic [15:0] u);
    ate(c);
    sensor_pronto = 1'b1; sensor_erro = err; sensor_temperatura = t; sensor_umidade = u;
    ate(c + 1);
    sensor_pronto = 1'b0; sensor_erro = 1'b0;
  endtask

  task automatic fim_tx(input int c);
    ate(c);
    transmissao_pronto = 1'b1;
    ate(c + 1);
    transmissao_pronto = 1'b0;
  endtask

  initial begin
    int p1, p2, p3, p4, p5, p6, p7, base;
    reset = 1'b1; ligar = 1'b0; sensor_pronto = 1'b0; sensor_erro = 1'b0;
    transmissao_pronto = 1'b0; sensor_temperatura = '0; sensor_umidade = '0;

    ate(3);
    reset = 1'b0;
    ate(4);
    check("reset_db", 32'(db_estado), 32'h0);
    check("reset_temp", 32'(temperatura), 32'h0);
    check("reset_ocupado", 32'(ocupado), 32'h0);

    // Normal cycle: medir one cycle after ligar, answer after 5 cycles.
    ate(5);
    ligar = 1'b1;
    p1 = 6;
    ate(p1);
    check("medir_latencia", 32'(medir), 32'h1);
    resposta(p1 + 5, 1'b0, 16'h1524, 16'h095E);
    ate(p1 + 7);
    check("transmite_2_ciclos", 32'(transmite), 32'h1);
    check("temp_1524", 32'(temperatura), 32'h1524);
    check("umid_095e", 32'(umidade), 32'h095E);
    fim_tx(p1 + 10);

    // Sensor silent: timeout, no transmission, values kept.
    p2 = p1 + INTERVALO;
    ate(p2);
    check("periodo_200", 32'(medir), 32'h1);
    base = n_tx;
`ifdef CONTROLE_MEDICAO_RETENTATIVA_EN
    ate(p2 + 21);
    check("retry_medir", 32'(medir), 32'h1);
    ate(p2 + 42);
    check("timeout_erro", 32'(db_estado), 32'hF);
    ate(p2 + 43);
`else
    ate(p2 + 21);
    check("timeout_erro", 32'(db_estado), 32'hF);
    ate(p2 + 22);
`endif
    check("erro_sticky", 32'(erro_sensor), 32'h1);
    check("temp_mantida", 32'(temperatura), 32'h1524);

    p3 = p2 + INTERVALO;
    ate(p3 - 1);
    check("sem_transmite", 32'(n_tx), 32'(base));
    resposta(p3 + 5, 1'b0, 16'h0102, 16'h0304);
    check("erro_ate_armazena", 32'(erro_sensor), 32'h1);
    ate(p3 + 7);
    check("erro_limpo", 32'(erro_sensor), 32'h0);
    check("temp_0102", 32'(temperatura), 32'h0102);
    fim_tx(p3 + 10);

    // Sensor reports an error; a later good answer only counts with retry enabled.
    p4 = p3 + INTERVALO;
    resposta(p4 + 3, 1'b1, 16'hDEAD, 16'hBEEF);
`ifdef CONTROLE_MEDICAO_RETENTATIVA_EN
    check("retry_apos_erro", 32'(medir), 32'h1);
`else
    check("erro_sensor_estado", 32'(db_estado), 32'hF);
    ate(p4 + 5);
    check("erro_sensor_flag", 32'(erro_sensor), 32'h1);
`endif
    resposta(p4 + 9, 1'b0, 16'h0A0B, 16'h0C0D);
    ate(p4 + 11);
`ifdef CONTROLE_MEDICAO_RETENTATIVA_EN
    check("retry_transmite", 32'(transmite), 32'h1);
    check("retry_temp", 32'(temperatura), 32'h0A0B);
`else
    check("pronto_ignorado", 32'(transmite), 32'h0);
    check("temp_sem_retry", 32'(temperatura), 32'h0102);
`endif
    fim_tx(p4 + 15);
    fim_tx(p4 + 50);

    // ligar dropped while waiting for the transmitter.
    p5 = p4 + INTERVALO;
    resposta(p5 + 5, 1'b0, 16'h1111, 16'h2222);
    ate(p5 + 8);
    ligar = 1'b0;
    check("ocupado_tx", 32'(ocupado), 32'h1);
    fim_tx(p5 + 12);
    check("espera_apos_tx", 32'(db_estado), 32'h1);
    ate(p5 + 14);
    check("volta_inicial", 32'(db_estado), 32'h0);
    base = n_medir;
    ate(p5 + 210);
    check("sem_medir", 32'(n_medir), 32'(base));

    // Transmitter longer than the period: the missed period is skipped.
    ligar = 1'b1;
    p6 = p5 + 211;
    ate(p6);
    check("religar_medir", 32'(medir), 32'h1);
    resposta(p6 + 5, 1'b0, 16'h3333, 16'h4444);
    ate(p6 + 200);
    check("periodo_perdido", 32'(medir), 32'h0);
    fim_tx(p6 + 257);
    p7 = p6 + 2 * INTERVALO;
    ate(p7);
    check("periodo_400", 32'(medir), 32'h1);

    // Asynchronous reset in the middle of AGUARDA_SENSOR.
    ate(p7 + 3);
    check("antes_reset", 32'(db_estado), 32'h3);
    #2 reset = 1'b1;
    #1;
    check("reset_async_db", 32'(db_estado), 32'h0);
    check("reset_async_temp", 32'(temperatura), 32'h0);
    check("reset_async_umid", 32'(umidade), 32'h0);
    check("reset_async_ocupado", 32'(ocupado), 32'h0);
    ate(p7 + 6);
    reset = 1'b0;
    ate(p7 + 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
